// File: rtl/button_input_pkg.sv
// rtl/button_input_pkg.sv - shared types and constants for the push-button input path
package button_input_pkg;

    // Auto-repeat state encoding, one instance per button channel
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2
    } rep_state_t;

    // Clock cycles per millisecond at 12 MHz
    localparam int CYCLES_PER_MS = 12000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - synchroniser, debounce filter and auto-repeat for one key
module button_channel
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10 * CYCLES_PER_MS,
    parameter int REPEAT_DELAY    = 500 * CYCLES_PER_MS,
    parameter int REPEAT_PERIOD   = 100 * CYCLES_PER_MS
) (
    input  logic clk12MHz,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    // One extra count of headroom keeps the widths >= 1 even for values of 1
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic          sync1;
    logic          sync2;
    logic          raw;
    logic [CW-1:0] db_cnt;
    logic          stable;
    logic          rise;
    logic          fall;
    rep_state_t    state;
    rep_state_t    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          delay_done;
    logic          period_done;
    logic          repeat_fire;

    // Two-flop synchroniser; resets to "released" so a held key cannot glitch
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign raw = ~sync2;

    // Debounce: flip the stable level only after DEBOUNCE_CYCLES unequal samples in a row
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (raw == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= ~stable;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // pressed trails stable by one cycle, so the difference marks the edges
    assign rise = stable & ~pressed;
    assign fall = ~stable & pressed;

    // Registered level and event outputs
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            pressed       <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            pressed       <= stable;
            press         <= rise;
            release_pulse <= fall;
            repeat_pulse  <= repeat_fire;
        end
    end

    // Repeat FSM state and timer register
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state <= RELEASED;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    assign delay_done  = (timer == TW'(REPEAT_DELAY - 1));
    assign period_done = (timer == TW'(REPEAT_PERIOD - 1));

    // Repeat FSM next state; a release overrides everything else
    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        case (state)
            RELEASED: begin
                timer_next = '0;
                if (rise) begin
                    state_next = DELAY;
                end
            end
            DELAY: begin
                if (delay_done) begin
                    state_next = REPEAT;
                    timer_next = '0;
                end
            end
            REPEAT: begin
                if (period_done) begin
                    timer_next = '0;
                end
            end
            default: begin
                state_next = RELEASED;
                timer_next = '0;
            end
        endcase
        if (fall) begin
            state_next = RELEASED;
            timer_next = '0;
        end
    end

    // Repeat FSM output: terminal count fires unless the key is being released
    always_comb begin
        repeat_fire = 1'b0;
        if (!fall) begin
            repeat_fire = ((state == DELAY) && delay_done) ||
                          ((state == REPEAT) && period_done);
        end
    end

endmodule

// File: rtl/button_input.sv
// rtl/button_input.sv - debounced level, press/release and auto-repeat events for the board keys
module button_input
    import button_input_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 10 * CYCLES_PER_MS,
    parameter int REPEAT_DELAY    = 500 * CYCLES_PER_MS,
    parameter int REPEAT_PERIOD   = 100 * CYCLES_PER_MS
) (
    input  logic                   clk12MHz,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] key_n,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] repeat_pulse
);

    // One fully independent channel per key
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk12MHz      (clk12MHz),
            .reset         (reset),
            .key_n         (key_n[i]),
            .pressed       (pressed[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_input.sv
// tb/tb_button_input.sv - directed self-checking bench for button_input
module tb_button_input;

    logic       clk12MHz = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] key_n    = 4'hF;
    logic [3:0] pressed;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] repeat_pulse;

    int compared   = 0;
    int mismatched = 0;

    button_input #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk12MHz      (clk12MHz),
        .reset         (reset),
        .key_n         (key_n),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk12MHz = ~clk12MHz;

    task automatic tick();
        @(posedge clk12MHz);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic is_rep(input int c, input int first, input int last);
        return (c >= first) && (c <= last) && (((c - first) % 3) == 0);
    endfunction

    initial begin
        // Key 0 held through reset: outputs stay 0, fresh press 6 cycles after deassert
        key_n = 4'b1110;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_outputs", i, {pressed, press, release_pulse, repeat_pulse}, 32'h0);
        end
        reset = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            tick();
            chk("t1_pressed", c, pressed, (c >= 6) ? 4'b0001 : 4'b0000);
            chk("t1_press", c, press, (c == 6) ? 4'b0001 : 4'b0000);
            chk("t1_release", c, release_pulse, 4'b0000);
        end

        // Release bounce on key 0: high 2, low 1, then high for good
        key_n[0] = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            tick();
            chk("bounce_pressed0", c, pressed[0], (c < 9) ? 1'b1 : 1'b0);
            chk("bounce_release0", c, release_pulse[0], (c == 9) ? 1'b1 : 1'b0);
            chk("bounce_press0", c, press[0], 1'b0);
            if (c == 1) key_n[0] = 1'b0;
            if (c == 2) key_n[0] = 1'b1;
        end

        // Glitch of DEBOUNCE_CYCLES-1 samples on key 0 is rejected
        key_n[0] = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            tick();
            chk("glitch_key0", c, {pressed[0], press[0], release_pulse[0]}, 3'b000);
            if (c == 2) key_n[0] = 1'b1;
        end

        // Key 1 held for 30 cycles: press, repeat train, release
        key_n[1] = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            tick();
            chk("t3_press1", c, press[1], (c == 6) ? 1'b1 : 1'b0);
            chk("t3_repeat1", c, repeat_pulse[1], is_rep(c, 16, 34));
            chk("t3_release1", c, release_pulse[1], (c == 36) ? 1'b1 : 1'b0);
            chk("t3_pressed1", c, pressed[1], ((c >= 6) && (c < 36)) ? 1'b1 : 1'b0);
            if (c == 29) key_n[1] = 1'b1;
        end

        // Keys 2 and 3 pressed on the same edge, released on the same edge
        key_n[3:2] = 2'b00;
        for (int c = 0; c <= 28; c++) begin
            tick();
            chk("t4_press23", c, press[3:2], (c == 6) ? 2'b11 : 2'b00);
            chk("t4_repeat23", c, repeat_pulse[3:2], is_rep(c, 16, 25) ? 2'b11 : 2'b00);
            chk("t4_release23", c, release_pulse[3:2], (c == 26) ? 2'b11 : 2'b00);
            chk("t4_other_press", c, press[1:0], 2'b00);
            if (c == 19) key_n[3:2] = 2'b11;
        end

        // One-cycle reset at cycle 12 while key 1 is held
        key_n[1] = 1'b0;
        for (int c = 0; c <= 31; c++) begin
            tick();
            chk("t5_pressed1", c, pressed[1], (((c >= 6) && (c < 12)) || (c >= 19)) ? 1'b1 : 1'b0);
            chk("t5_press1", c, press[1], ((c == 6) || (c == 19)) ? 1'b1 : 1'b0);
            chk("t5_repeat1", c, repeat_pulse[1], (c == 29) ? 1'b1 : 1'b0);
            chk("t5_release1", c, release_pulse[1], 1'b0);
            if (c == 11) reset = 1'b1;
            if (c == 12) reset = 1'b0;
        end
        key_n = 4'hF;
        for (int i = 0; i < 10; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
